// File: rtl/hub75_column_driver_if.sv
// ---------------------------------------------------------------------------
// hub75_column_driver_if
// Line-pair hand-over from the frame/column manager to the HUB75 column
// driver. The transfer happens when valid and ready are both high.
//   line_valid_in  : upstream has a line pair
//   line_ready_out : driver's pending buffer is empty
//   line_addr_in   : scan address of line A
//   line_data_in   : [1:0][PIXELS-1:0][RGB_RES-1:0], index 0 = line A,
//                    index 1 = line B
// master = upstream producer, slave = column driver.
// ---------------------------------------------------------------------------
interface hub75_column_driver_if #(
  parameter int PIXELS    = 64,
  parameter int SCAN_RATE = 32,
  parameter int RGB_RES   = 9
);
  logic                                 line_valid_in;
  logic                                 line_ready_out;
  logic [$clog2(SCAN_RATE)-1:0]         line_addr_in;
  logic [1:0][PIXELS-1:0][RGB_RES-1:0]  line_data_in;

  modport master (
    output line_valid_in, line_addr_in, line_data_in,
    input  line_ready_out
  );

  modport slave (
    input  line_valid_in, line_addr_in, line_data_in,
    output line_ready_out
  );
endinterface

// File: rtl/hub75_column_driver.sv
// ---------------------------------------------------------------------------
// hub75_column_driver
// Final POV output stage. Takes one scan-line pair per transfer and drives a
// HUB75 panel with binary-coded modulation: for each bitplane k the pixels are
// shifted out, latched, then lit for BASE_ON<<k cycles.
// A one-deep pending buffer accepts the next line while the current one is
// still on the panel.
// Ports:
//   clk_in, rst_in        : clock, synchronous active-low reset
//   line_if (slave)       : line-pair handshake (valid/ready/addr/data)
//   hub_{r,g,b}0_out      : line A serial data
//   hub_{r,g,b}1_out      : line B serial data
//   hub_clk_out           : panel shift clock
//   hub_lat_out           : panel latch
//   hub_oe_n_out          : panel output enable, active low
//   hub_addr_out          : panel row-pair address
//   busy_out              : a line is being shifted/displayed
// All panel outputs are registered.
// ---------------------------------------------------------------------------
module hub75_column_driver #(
  parameter int PIXELS    = 64,
  parameter int SCAN_RATE = 32,
  parameter int RGB_RES   = 9,
  parameter int BASE_ON   = 4
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  hub75_column_driver_if.slave         line_if,
  output logic                         hub_r0_out,
  output logic                         hub_g0_out,
  output logic                         hub_b0_out,
  output logic                         hub_r1_out,
  output logic                         hub_g1_out,
  output logic                         hub_b1_out,
  output logic                         hub_clk_out,
  output logic                         hub_lat_out,
  output logic                         hub_oe_n_out,
  output logic [$clog2(SCAN_RATE)-1:0] hub_addr_out,
  output logic                         busy_out
);

  localparam int ADDR_W   = $clog2(SCAN_RATE);
  localparam int BCM_BITS = RGB_RES / 3;
  localparam int PIX_W    = $clog2(PIXELS);
  localparam int CNT_W    = PIX_W + 1;              // pixel index + phase bit
  localparam int PL_W     = (BCM_BITS > 1) ? $clog2(BCM_BITS) : 1;
  localparam int OE_MAX   = BASE_ON << (BCM_BITS - 1);
  localparam int OE_W     = $clog2(OE_MAX + 1);
  localparam int IDX_W    = $clog2(RGB_RES);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * PIXELS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PIX_W-1:0] PIX_ONE  = PIX_W'(1);
  localparam logic [PL_W-1:0]  PL_LAST  = PL_W'(BCM_BITS - 1);
  localparam logic [PL_W-1:0]  PL_ONE   = PL_W'(1);
  localparam logic [OE_W-1:0]  OE_ONE   = OE_W'(1);

  typedef logic [1:0][PIXELS-1:0][RGB_RES-1:0] line_t;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH, S_DISPLAY} state_t;

  // pending / active line buffers
  logic              r_pend_valid;
  logic [ADDR_W-1:0] r_pend_addr;
  line_t             r_pend_data;
  logic [ADDR_W-1:0] r_act_addr;
  line_t             r_act_data;
  logic              r_ready;

  // FSM state and counters
  state_t            r_state;
  logic [PL_W-1:0]   r_plane;
  logic [CNT_W-1:0]  r_cnt;
  logic [OE_W-1:0]   r_oe_cnt;

  // registered panel outputs
  logic [5:0]        r_rgb;       // {r0,g0,b0,r1,g1,b1}
  logic              r_clk;
  logic              r_lat;
  logic              r_oe_n;
  logic              r_busy;
  logic [ADDR_W-1:0] r_addr;

  logic              w_capture;
  logic              w_promote;
  logic              w_pend_next;
  logic [PIX_W-1:0]  w_pix_next;
  logic [PL_W-1:0]   w_plane_next;
  logic [31:0]       w_oe_len;
  logic              w_oe_done;

  // Plane-k bits of pixel p for both lines: R at 2*BCM+k, G at BCM+k, B at k.
  function automatic logic [5:0] plane_bits(line_t d, logic [PIX_W-1:0] p,
                                            logic [PL_W-1:0] k);
    logic [IDX_W-1:0] ir, ig, ib;
    ir = IDX_W'(2 * BCM_BITS) + IDX_W'(k);
    ig = IDX_W'(BCM_BITS) + IDX_W'(k);
    ib = IDX_W'(k);
    return {d[0][p][ir], d[0][p][ig], d[0][p][ib],
            d[1][p][ir], d[1][p][ig], d[1][p][ib]};
  endfunction

  assign w_capture    = line_if.line_valid_in && r_ready;
  assign w_promote    = (r_state == S_IDLE) && r_pend_valid;
  // A capture may coincide with a promotion; the new line then stays pending.
  assign w_pend_next  = w_capture || (r_pend_valid && !w_promote);
  assign w_pix_next   = r_cnt[CNT_W-1:1] + PIX_ONE;
  assign w_plane_next = r_plane + PL_ONE;
  assign w_oe_len     = 32'(BASE_ON) << r_plane;
  assign w_oe_done    = (32'(r_oe_cnt) == (w_oe_len - 32'd1));

  // -------------------------------------------------------------------------
  // Pending buffer and ready flag
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_pend_valid <= 1'b0;
      r_ready      <= 1'b0;
    end else begin
      r_pend_valid <= w_pend_next;
      r_ready      <= !w_pend_next;
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_capture) begin
      r_pend_addr <= line_if.line_addr_in;
      r_pend_data <= line_if.line_data_in;
    end
  end

  assign line_if.line_ready_out = r_ready;

  // -------------------------------------------------------------------------
  // BCM FSM. Outputs are loaded with the values belonging to the state being
  // entered, so they line up with the state register cycle for cycle.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state    <= S_IDLE;
      r_plane    <= '0;
      r_cnt      <= '0;
      r_oe_cnt   <= '0;
      r_act_addr <= '0;
      r_rgb      <= '0;
      r_clk      <= 1'b0;
      r_lat      <= 1'b0;
      r_oe_n     <= 1'b1;
      r_busy     <= 1'b0;
      r_addr     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (r_pend_valid) begin
            r_act_data <= r_pend_data;
            r_act_addr <= r_pend_addr;
            r_state    <= S_SHIFT;
            r_plane    <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_clk      <= 1'b0;
            // active buffer is loaded this edge, so read pixel 0 from pending
            r_rgb      <= plane_bits(r_pend_data, '0, '0);
          end
        end

        S_SHIFT: begin
          if (r_cnt == CNT_LAST) begin
            r_state <= S_LATCH;
            r_clk   <= 1'b0;
            r_lat   <= 1'b1;
            r_addr  <= r_act_addr;       // address moves only while blanked
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
            if (r_cnt[0]) begin          // end of phase 1: next pixel
              r_clk <= 1'b0;
              r_rgb <= plane_bits(r_act_data, w_pix_next, r_plane);
            end else begin
              r_clk <= 1'b1;
            end
          end
        end

        S_LATCH: begin
          r_state  <= S_DISPLAY;
          r_lat    <= 1'b0;
          r_oe_n   <= 1'b0;
          r_oe_cnt <= '0;
        end

        S_DISPLAY: begin
          if (w_oe_done) begin
            r_oe_n <= 1'b1;
            if (r_plane == PL_LAST) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_rgb   <= '0;
            end else begin
              r_state <= S_SHIFT;
              r_plane <= w_plane_next;
              r_cnt   <= '0;
              r_rgb   <= plane_bits(r_act_data, '0, w_plane_next);
            end
          end else begin
            r_oe_cnt <= r_oe_cnt + OE_ONE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign {hub_r0_out, hub_g0_out, hub_b0_out,
          hub_r1_out, hub_g1_out, hub_b1_out} = r_rgb;
  assign hub_clk_out  = r_clk;
  assign hub_lat_out  = r_lat;
  assign hub_oe_n_out = r_oe_n;
  assign hub_addr_out = r_addr;
  assign busy_out     = r_busy;

endmodule

// File: tb/tb_hub75_column_driver.sv
// ---------------------------------------------------------------------------
// tb_hub75_column_driver
// Directed bench for hub75_column_driver with a line-timeline reference model
// and a few hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_hub75_column_driver;
  localparam int P   = 64;
  localparam int SR  = 32;
  localparam int RES = 9;
  localparam int BON = 4;
  localparam int NB  = RES / 3;
  localparam int AW  = $clog2(SR);
  localparam int LINE_CYC = NB * (2 * P + 1) + BON * ((1 << NB) - 1);

  typedef logic [1:0][P-1:0][RES-1:0] ldata_t;
  typedef struct {
    int     cap;
    int     start;
    int     addr;
    ldata_t data;
  } mline_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic r0, g0, b0, r1, g1, b1, hclk, lat, oe_n, busy;
  logic [AW-1:0] haddr;

  hub75_column_driver_if #(.PIXELS(P), .SCAN_RATE(SR), .RGB_RES(RES)) lif ();

  hub75_column_driver #(.PIXELS(P), .SCAN_RATE(SR), .RGB_RES(RES), .BASE_ON(BON)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .line_if      (lif),
    .hub_r0_out   (r0),
    .hub_g0_out   (g0),
    .hub_b0_out   (b0),
    .hub_r1_out   (r1),
    .hub_g1_out   (g1),
    .hub_b1_out   (b1),
    .hub_clk_out  (hclk),
    .hub_lat_out  (lat),
    .hub_oe_n_out (oe_n),
    .hub_addr_out (haddr),
    .busy_out     (busy)
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic bitof(input int v, input int i);
    return ((v >> i) & 1) == 1;
  endfunction

  // -------------------------------------------------------------------------
  // Reference model: each accepted line owns a LINE_CYC-cycle window starting
  // two cycles after capture, or one IDLE cycle after the previous window.
  // Position inside the window gives plane, pixel and phase arithmetically.
  // -------------------------------------------------------------------------
  mline_t q[$];
  int     last_start = -100000;
  logic   rst_prev   = 1'b0;
  int     m_addr     = 0;
  logic [AW-1:0] prev_addr = '0;
  int     idle_run = 0;
  int     gaps[$];
  int     lat_addrs[$];

  always @(negedge clk_in) begin
    logic e_ready, e_oe_n, e_lat, e_clk, e_busy, chk_dat;
    logic [5:0] e_dat;
    int t, k, pa, pb;
    mline_t m;
    e_ready = 1'b0; e_oe_n = 1'b1; e_lat = 1'b0; e_clk = 1'b0;
    e_busy = 1'b0; chk_dat = 1'b1; e_dat = '0;
    if (rst_prev) begin
      while (q.size() > 0 && cyc >= q[0].start + LINE_CYC) void'(q.pop_front());
      e_ready = 1'b1;
      foreach (q[i]) if (cyc >= q[i].cap + 1 && cyc <= q[i].start - 1) e_ready = 1'b0;
      if (q.size() > 0 && cyc >= q[0].start) begin
        e_busy = 1'b1;
        t = cyc - q[0].start;
        k = 0;
        while (t >= 2 * P + 1 + (BON << k)) begin
          t -= 2 * P + 1 + (BON << k);
          k++;
        end
        if (t < 2 * P) begin
          e_clk = (t % 2) == 1;
          pa = int'(q[0].data[0][t/2]);
          pb = int'(q[0].data[1][t/2]);
          e_dat = {bitof(pa, 2*NB+k), bitof(pa, NB+k), bitof(pa, k),
                   bitof(pb, 2*NB+k), bitof(pb, NB+k), bitof(pb, k)};
        end else begin
          chk_dat = 1'b0;
          if (t == 2 * P) begin
            e_lat  = 1'b1;
            m_addr = q[0].addr;
          end else begin
            e_oe_n = 1'b0;
          end
        end
      end
    end

    chk("ready", lif.line_ready_out, e_ready);
    chk("oe_n",  oe_n, e_oe_n);
    chk("lat",   lat,  e_lat);
    chk("hclk",  hclk, e_clk);
    chk("busy",  busy, e_busy);
    chk("addr",  haddr, m_addr);
    if (chk_dat) chk("data", {r0, g0, b0, r1, g1, b1}, e_dat);

    if (rst_prev && haddr !== prev_addr) chk("addr_move_blanked", {oe_n, lat}, 2'b11);
    prev_addr = haddr;
    if (lat) lat_addrs.push_back(int'(haddr));
    if (!busy) idle_run++;
    else begin
      if (idle_run > 0) gaps.push_back(idle_run);
      idle_run = 0;
    end

    if (!rst_in) begin
      q.delete();
      m_addr = 0;
      last_start = -100000;
    end else if (lif.line_valid_in && e_ready) begin
      m.cap   = cyc;
      m.start = (cyc + 2 > last_start + LINE_CYC + 1) ? cyc + 2 : last_start + LINE_CYC + 1;
      m.addr  = int'(lif.line_addr_in);
      m.data  = lif.line_data_in;
      q.push_back(m);
      last_start = m.start;
    end
    rst_prev = rst_in;
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  // Called just after a rising edge; returns just after the transfer edge.
  task automatic send_line(input int addr, input ldata_t d);
    int guard = 0;
    lif.line_valid_in = 1'b1;
    lif.line_addr_in  = AW'(addr);
    lif.line_data_in  = d;
    @(negedge clk_in);
    while (!lif.line_ready_out && guard < 2000) begin
      guard++;
      @(negedge clk_in);
    end
    chk("handshake_timeout", guard < 2000, 1);
    @(posedge clk_in);
    #1;
  endtask

  function automatic ldata_t rand_line();
    ldata_t d;
    for (int l = 0; l < 2; l++)
      for (int p = 0; p < P; p++) d[l][p] = RES'($urandom_range(0, (1 << RES) - 1));
    return d;
  endfunction

  int m_busy, m_lat, m_ones;
  int rise_cnt[3];
  int oe_win[3];
  logic [2:0] rec_a[3][P];

  // Observes one complete line on the panel pins.
  task automatic measure_line();
    int guard = 0, plane = 0, pix = 0, run = 0, nwin = 0;
    m_busy = 0; m_lat = 0; m_ones = 0;
    for (int i = 0; i < 3; i++) begin rise_cnt[i] = 0; oe_win[i] = 0; end
    @(negedge clk_in);
    while (!busy && guard < 20) begin guard++; @(negedge clk_in); end
    chk("line_start", busy, 1);
    while (busy && m_busy < 1000) begin
      m_busy++;
      if (hclk && plane < 3) begin
        if (pix < P) rec_a[plane][pix] = {r0, g0, b0};
        pix++;
        rise_cnt[plane]++;
        if (r0 && g0 && b0 && !r1 && !g1 && !b1) m_ones++;
      end
      if (lat) m_lat++;
      if (!oe_n) run++;
      else if (run > 0) begin
        if (nwin < 3) oe_win[nwin] = run;
        nwin++; run = 0; plane++; pix = 0;
      end
      @(negedge clk_in);
    end
    if (run > 0 && nwin < 3) oe_win[nwin] = run;
  endtask

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  initial begin
    ldata_t d;
    int guard;
    lif.line_valid_in = 1'b0;
    lif.line_addr_in  = '0;
    lif.line_data_in  = '0;
    rst_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b1;
    @(negedge clk_in);
    chk("reset_ready", lif.line_ready_out, 0);
    chk("reset_oe_n", oe_n, 1);
    @(negedge clk_in);
    chk("ready_after_release", lif.line_ready_out, 1);
    @(posedge clk_in); #1;

    // line 1: A all ones, B all zeros, addr 5
    for (int p = 0; p < P; p++) begin d[0][p] = 9'h1FF; d[1][p] = 9'h000; end
    send_line(5, d);
    lif.line_valid_in = 1'b0;
    measure_line();
    chk("t1_line_cycles", m_busy, 415);
    chk("t1_lat_pulses", m_lat, 3);
    chk("t1_rises_p0", rise_cnt[0], 64);
    chk("t1_rises_p1", rise_cnt[1], 64);
    chk("t1_rises_p2", rise_cnt[2], 64);
    chk("t1_ones_on_rise", m_ones, 192);
    chk("t1_oe_win0", oe_win[0], 4);
    chk("t1_oe_win1", oe_win[1], 8);
    chk("t1_oe_win2", oe_win[2], 16);
    chk("t1_addr", haddr, 5);

    // line 2: only pixel 3 of A set to 101_010_001
    @(posedge clk_in); #1;
    d = '0;
    d[0][3] = 9'b101_010_001;
    send_line(7, d);
    lif.line_valid_in = 1'b0;
    measure_line();
    chk("t2_p0_px3", rec_a[0][3], 3'b101);
    chk("t2_p1_px3", rec_a[1][3], 3'b010);
    chk("t2_p2_px3", rec_a[2][3], 3'b100);
    chk("t2_p0_px2", rec_a[0][2], 3'b000);
    chk("t2_addr", haddr, 7);

    // back-to-back lines with valid held high
    @(posedge clk_in); #1;
    lat_addrs.delete();
    gaps.delete();
    send_line(1, rand_line());
    send_line(2, rand_line());
    send_line(3, rand_line());
    lif.line_valid_in = 1'b0;
    repeat (900) @(negedge clk_in);
    chk("t3_lat_count", lat_addrs.size(), 9);
    for (int i = 0; i < lat_addrs.size() && i < 9; i++)
      chk("t3_lat_addr_order", lat_addrs[i], i / 3 + 1);
    chk("t3_gap_count", gaps.size(), 3);
    if (gaps.size() == 3) begin
      chk("t3_gap_1_2", gaps[1], 1);
      chk("t3_gap_2_3", gaps[2], 1);
    end

    // reset in the middle of plane-1 shifting
    @(posedge clk_in); #1;
    send_line(9, rand_line());
    lif.line_valid_in = 1'b0;
    guard = 0;
    @(negedge clk_in);
    while (!busy && guard < 20) begin guard++; @(negedge clk_in); end
    chk("t4_start", busy, 1);
    repeat (2 * P + 1 + BON + 20) @(negedge clk_in);
    chk("t4_pre_addr", haddr, 9);
    @(posedge clk_in); #1 rst_in = 1'b0;
    @(posedge clk_in); #1 rst_in = 1'b1;
    @(negedge clk_in);
    chk("t4_rst_oe_n", oe_n, 1);
    chk("t4_rst_lat", lat, 0);
    chk("t4_rst_addr", haddr, 0);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_hclk", hclk, 0);
    @(posedge clk_in); #1;
    send_line(12, rand_line());
    lif.line_valid_in = 1'b0;
    measure_line();
    chk("t4_line_cycles", m_busy, 415);
    chk("t4_lat_pulses", m_lat, 3);
    chk("t4_addr", haddr, 12);

    repeat (5) @(negedge clk_in);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
